// File: rtl/ps2_mouse_pkg.sv
// Shared types and constants for the PS/2 mouse packet receiver.
// Holds the FSM state enum, command/ack bytes and byte-0 bit positions.
package ps2_mouse_pkg;

  typedef enum logic [2:0] {HOLD, REQ, TX, ACK, RXACK, STREAM} state_t;

  localparam logic [7:0] CMD_STREAM_EN = 8'hF4;
  localparam logic [7:0] ACK_BYTE      = 8'hFA;

  localparam int B0_L    = 0;
  localparam int B0_R    = 1;
  localparam int B0_SYNC = 3;
  localparam int B0_XS   = 4;
  localparam int B0_YS   = 5;
  localparam int B0_XOV  = 6;
  localparam int B0_YOV  = 7;

  // Parity bit that gives the byte plus parity an odd number of ones.
  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_mouse_packet_rx_frame_rx.sv
// PS/2 line conditioning and device-to-host frame receiver.
// Synchronises both lines, glitch-filters the clock and checks 11-bit frames.
module ps2_frame_rx #(
  parameter int TIMEOUT_CYC = 100000,
  parameter int FILT_LEN    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2c,
  input  logic       ps2d,
  input  logic       en,
  output logic [7:0] rx_byte,
  output logic       byte_ok,
  output logic       byte_err,
  output logic       fall,
  output logic       data
);

  localparam int GW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYC - 1);

  logic                c_meta_reg, c_sync_reg, d_meta_reg, d_sync_reg;
  logic [FILT_LEN-1:0] filt_sr_reg;
  logic                filt_reg, filt_next, fall_reg;
  logic [3:0]          bit_cnt_reg;
  logic [9:0]          shift_reg;
  logic [GW-1:0]       gap_reg;
  logic [10:0]         frame;
  logic                frame_end, frame_good, timeout;

  // Idle lines are high, so conditioning starts from 1 to avoid a false fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_meta_reg  <= 1'b1;
      c_sync_reg  <= 1'b1;
      d_meta_reg  <= 1'b1;
      d_sync_reg  <= 1'b1;
      filt_sr_reg <= '1;
      filt_reg    <= 1'b1;
      fall_reg    <= 1'b0;
    end else begin
      c_meta_reg  <= ps2c;
      c_sync_reg  <= c_meta_reg;
      d_meta_reg  <= ps2d;
      d_sync_reg  <= d_meta_reg;
      filt_sr_reg <= {filt_sr_reg[FILT_LEN-2:0], c_sync_reg};
      filt_reg    <= filt_next;
      fall_reg    <= filt_reg & ~filt_next;
    end
  end

  always_comb begin
    filt_next = filt_reg;
    if (&filt_sr_reg)
      filt_next = 1'b1;
    else if (~|filt_sr_reg)
      filt_next = 1'b0;
  end

  // The bit arriving on the stop fall completes the frame: {stop, parity, data, start}.
  assign frame      = {d_sync_reg, shift_reg};
  assign frame_end  = en && fall_reg && (bit_cnt_reg == 4'd10);
  assign frame_good = !frame[0] && (^frame[9:1]) && frame[10];
  assign timeout    = en && !fall_reg && (bit_cnt_reg != 4'd0) && (gap_reg == GAP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_reg <= 4'd0;
      shift_reg   <= 10'd0;
      gap_reg     <= '0;
    end else if (!en) begin
      bit_cnt_reg <= 4'd0;
      gap_reg     <= '0;
    end else if (fall_reg) begin
      bit_cnt_reg <= (bit_cnt_reg == 4'd10) ? 4'd0 : bit_cnt_reg + 4'd1;
      shift_reg   <= {d_sync_reg, shift_reg[9:1]};
      gap_reg     <= '0;
    end else if (timeout) begin
      bit_cnt_reg <= 4'd0;
      gap_reg     <= '0;
    end else if (bit_cnt_reg != 4'd0) begin
      gap_reg <= gap_reg + 1'b1;
    end
  end

  assign rx_byte  = frame[8:1];
  assign byte_ok  = frame_end && frame_good;
  assign byte_err = (frame_end && !frame_good) || timeout;
  assign fall     = fall_reg;
  assign data     = d_sync_reg;

endmodule

// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse host: enables streaming with 0xF4, then assembles 3-byte
// movement packets into registered deltas/buttons with a one-cycle tick.
module ps2_mouse_packet_rx
  import ps2_mouse_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int HOLD_CYC    = CLK_HZ / 10000,
  parameter int TIMEOUT_CYC = CLK_HZ / 500,
  parameter int FILT_LEN    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic [8:0] xm,
  output logic [8:0] ym,
  output logic       left,
  output logic       right,
  output logic       packet_tick,
  output logic       init_done
);

  localparam int CW = $clog2(HOLD_CYC + TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYC - 1);
  localparam logic [8:0]    TX_VEC    = {odd_par(CMD_STREAM_EN), CMD_STREAM_EN};

  state_t        state_reg, state_next;
  logic [3:0]    bit_reg, bit_next, bit_inc;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          c_low_reg, c_low_next, d_low_reg, d_low_next;
  logic          init_reg, init_next;
  logic [7:0]    rx_byte;
  logic          byte_ok, byte_err, fall, data, rx_en;

  logic [1:0]    idx_reg;
  logic [7:0]    b0_reg, bx_reg;
  logic [8:0]    xm_reg, ym_reg;
  logic          left_reg, right_reg, tick_reg;

  assign ps2c  = c_low_reg ? 1'b0 : 1'bz;
  assign ps2d  = d_low_reg ? 1'b0 : 1'bz;
  assign rx_en = (state_reg == RXACK) || (state_reg == STREAM);

  ps2_frame_rx #(
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .FILT_LEN   (FILT_LEN)
  ) u_frame_rx (
    .clk     (clk),
    .rst_n   (rst_n),
    .ps2c    (ps2c),
    .ps2d    (ps2d),
    .en      (rx_en),
    .rx_byte (rx_byte),
    .byte_ok (byte_ok),
    .byte_err(byte_err),
    .fall    (fall),
    .data    (data)
  );

  // Line drives are registered so reset releases both lines immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= HOLD;
      bit_reg   <= 4'd0;
      cnt_reg   <= '0;
      c_low_reg <= 1'b0;
      d_low_reg <= 1'b0;
      init_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      bit_reg   <= bit_next;
      cnt_reg   <= cnt_next;
      c_low_reg <= c_low_next;
      d_low_reg <= d_low_next;
      init_reg  <= init_next;
    end
  end

  assign bit_inc = bit_reg + 4'd1;

  always_comb begin
    state_next = state_reg;
    bit_next   = bit_reg;
    c_low_next = 1'b0;
    d_low_next = 1'b0;
    init_next  = init_reg;
    case (state_reg)
      HOLD: begin
        c_low_next = 1'b1;
        if (cnt_reg == HOLD_LAST) begin
          d_low_next = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        d_low_next = 1'b1;
        if (fall) begin
          state_next = TX;
          bit_next   = 4'd0;
          d_low_next = ~TX_VEC[0];
        end
      end
      TX: begin
        d_low_next = ~TX_VEC[bit_reg];
        if (fall) begin
          if (bit_reg == 4'd8) begin
            state_next = ACK;
            d_low_next = 1'b0;
          end else begin
            bit_next   = bit_inc;
            d_low_next = ~TX_VEC[bit_inc];
          end
        end
      end
      ACK: begin
        if (fall)
          state_next = data ? HOLD : RXACK;
      end
      RXACK: begin
        if (byte_ok) begin
          if (rx_byte == ACK_BYTE) begin
            state_next = STREAM;
            init_next  = 1'b1;
          end else begin
            state_next = HOLD;
          end
        end else if (byte_err) begin
          state_next = HOLD;
        end
      end
      default: ;
    endcase
    // The device stopped clocking during the handshake: start over.
    if ((state_reg != HOLD) && (state_reg != STREAM) && !fall && (cnt_reg == TMO_LAST)) begin
      state_next = HOLD;
      d_low_next = 1'b0;
    end
    if ((state_next != state_reg) || (fall && (state_reg != HOLD)))
      cnt_next = '0;
    else if (state_reg != STREAM)
      cnt_next = cnt_reg + 1'b1;
    else
      cnt_next = cnt_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg   <= 2'd0;
      b0_reg    <= 8'd0;
      bx_reg    <= 8'd0;
      xm_reg    <= 9'd0;
      ym_reg    <= 9'd0;
      left_reg  <= 1'b0;
      right_reg <= 1'b0;
      tick_reg  <= 1'b0;
    end else begin
      tick_reg <= 1'b0;
      if (state_reg == STREAM) begin
        if (byte_err) begin
          idx_reg <= 2'd0;
        end else if (byte_ok) begin
          case (idx_reg)
            2'd0: begin
              // A byte without the always-one bit cannot be byte0: drop it to resync.
              if (rx_byte[B0_SYNC]) begin
                b0_reg  <= rx_byte;
                idx_reg <= 2'd1;
              end
            end
            2'd1: begin
              bx_reg  <= rx_byte;
              idx_reg <= 2'd2;
            end
            default: begin
              xm_reg    <= b0_reg[B0_XOV] ? 9'd0 : {b0_reg[B0_XS], bx_reg};
              ym_reg    <= b0_reg[B0_YOV] ? 9'd0 : {b0_reg[B0_YS], rx_byte};
              left_reg  <= b0_reg[B0_L];
              right_reg <= b0_reg[B0_R];
              tick_reg  <= 1'b1;
              idx_reg   <= 2'd0;
            end
          endcase
        end
      end
    end
  end

  assign xm          = xm_reg;
  assign ym          = ym_reg;
  assign left        = left_reg;
  assign right       = right_reg;
  assign packet_tick = tick_reg;
  assign init_done   = init_reg;

endmodule

// File: doc/ps2_mouse_packet_rx.md
Name: ps2_mouse_packet_rx

Overview:
- PS/2 host-side mouse interface that produces the mouse stimulus the board painter consumes: the 9-bit signed deltas xm/ym and the left/right buttons.
- After reset it enables streaming by sending command 0xF4 and checking the 0xFA acknowledge.
- It then receives 11-bit device frames and assembles 3-byte movement packets into registered outputs with a one-cycle packet_tick.
- Sits between the board PS/2 pins and the text/painter logic, in the same clk domain.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- HOLD_CYC, CLK_HZ/10000 (100 us), cycles ps2c is held low to request a host-to-device send.
- TIMEOUT_CYC, CLK_HZ/500 (2 ms), maximum gap between PS/2 clock falling edges inside a frame.
- FILT_LEN, 8, length of the ps2c glitch-filter shift register.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- ps2c  inout  1  PS/2 clock; the host drives only 0 or Z.
- ps2d  inout  1  PS/2 data; the host drives only 0 or Z.
- xm  out  9  X delta, two's complement {sign, byte1}.
- ym  out  9  Y delta, two's complement {sign, byte2}.
- left  out  1  left button level.
- right  out  1  right button level.
- packet_tick  out  1  one-cycle pulse; xm/ym/left/right were updated this cycle.
- init_done  out  1  high once streaming is enabled.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Every output is 0 and both lines are released (Z).
  - The FSM goes to HOLD; all counters clear.
  - Reset asserted mid-frame or mid-send aborts immediately; no partial packet is ever emitted.
- Input conditioning:
  - ps2c and ps2d each pass through a 2-FF synchroniser.
  - ps2c is then filtered: the filtered level goes to 0 when FILT_LEN consecutive samples are 0, and to 1 when FILT_LEN are 1.
  - fall = filtered 1->0 transition, a one-cycle strobe.
- FSM states:
  - HOLD:
    - Drive ps2c=0 for HOLD_CYC cycles.
    - On the last hold cycle also drive ps2d=0 (start bit).
    - Then go to REQ.
  - REQ: release ps2c and keep ps2d=0; on the first fall go to TX with bit index 0.
  - TX:
    - On each fall, present the next bit of the 9-bit vector {odd parity, 0xF4} LSB first; ps2d=0 for a 0 bit, Z for a 1 bit.
    - After the parity bit has been clocked, the next fall releases ps2d (stop bit) and moves to ACK.
  - ACK: on the next fall sample ps2d. 0 -> RXACK; 1 -> HOLD (retry).
  - RXACK:
    - Receive one frame (rules below).
    - Byte 0xFA -> STREAM and set init_done=1.
    - Any other byte or a frame error -> HOLD.
  - STREAM: receive frames forever; init_done stays 1 until reset.
  - Timeout: in REQ, TX, ACK and RXACK, TIMEOUT_CYC cycles without a fall returns to HOLD.
- Frame receive:
  - Shift ps2d on each fall: start, 8 data LSB first, parity, stop.
  - A frame is valid when start=0, the 9 bits data+parity have odd weight, and stop=1.
  - An invalid frame is discarded and the packet byte index resets to 0.
  - A gap of more than TIMEOUT_CYC mid-frame discards the partial frame; the byte index also resets to 0.
  - A frame is complete on the fall of its stop bit.
- Packet assembly (STREAM only):
  - Byte index 0 is byte0; it is accepted only if bit3=1. If bit3=0 the byte is dropped and the index stays 0 (resync).
  - Byte index 1 is X; byte index 2 is Y.
  - The cycle after the Y byte is accepted:
    - xm = {b0[4], X}, ym = {b0[5], Y}, left = b0[0], right = b0[1].
    - packet_tick = 1 for exactly one cycle.
    - The byte index wraps to 0.
  - Overflow: if b0[6]=1 then xm=0; if b0[7]=1 then ym=0.
  - All outputs hold their value until the next packet.
- Latency: outputs change exactly 1 clk after the falling edge of the third frame's stop bit, as seen through the synchroniser and filter.

Decomposition:
- Package ps2_mouse_pkg:
  - FSM state enum (HOLD, REQ, TX, ACK, RXACK, STREAM).
  - CMD_STREAM_EN=8'hF4, ACK_BYTE=8'hFA.
  - Byte0 bit positions: L=0, R=1, SYNC=3, XS=4, YS=5, XOV=6, YOV=7.
- One sub-module: ps2_frame_rx.
  - Contains the synchroniser, filter, fall strobe, the 11-bit shift and check, and the timeout.
  - Outputs: byte, byte_ok, byte_err, fall.
  - Shared by RXACK and STREAM.
  - The parent owns the FSM, the TX shifting and the packet assembly.

Test Plan:
- Reset, then device BFM clocks in request, acks, and returns 0xFA -> bench sees ps2c low ≥HOLD_CYC and bits 0,0,1,0,1,1,1,1 then parity 0 on ps2d; init_done=1.
- Stream 0x09,0x05,0xFE -> xm=9'h005, ym=9'h0FE, left=1, right=0, and packet_tick high for exactly 1 cycle.
- Stream 0x38,0xFB,0x02 -> xm=9'h1FB (−5), ym=9'h102, left=right=0.
- Stream stray 0x05 (bit3=0), then 0x0A,0x10,0x20 -> one packet: xm=9'h010, ym=9'h020, right=1; no tick for the stray byte.
- Y frame with a parity error, then a full valid packet 0x08,0x03,0x04 -> no tick from the bad packet; next tick gives xm=3, ym=4.
- Device replies 0xFE instead of 0xFA -> FSM returns to HOLD and resends 0xF4. Separately, rst_n pulsed mid-packet -> all outputs 0, lines Z, init repeats.
